// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and data load/store.
// Optional bus-stall timeout abort is built in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_data_q;
  logic        gnt_data_q;
  logic        first_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_sel_q;
  logic        bus_ren_q;
  logic        bus_wen_q;
  logic        i_ready_q;
  logic        d_ready_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        d_pend;
  logic        grant_any;
  logic        grant_data;
  logic        finish_d;
  logic        abort_d;
  logic [31:0] cap_data_d;

  // On contention the requester that did not win last time is served.
  always_comb begin
    d_pend     = d_ren | d_wen;
    grant_any  = i_req | d_pend;
    grant_data = d_pend & (~i_req | ~last_data_q);
    finish_d   = (state_q == S_ACCESS) && !first_q && !bus_busy;
    cap_data_d = abort_d ? ERR_DATA : (bus_wen_q ? 32'h0 : bus_rdata);
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;
  logic          bus_err_q;

  always_comb begin
    wait_cnt_d = (wait_cnt_q == {CW{1'b1}}) ? wait_cnt_q : wait_cnt_q + CW'(1);
  end

  assign abort_d = (state_q == S_ACCESS) && !first_q && bus_busy && (wait_cnt_d >= TO_LIM);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= abort_d;
      if (state_q == S_IDLE && grant_any) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_ACCESS && !first_q && bus_busy) begin
        wait_cnt_q <= wait_cnt_d;
      end
    end
  end

  assign bus_err = bus_err_q;
`else
  assign abort_d = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      first_q     <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      bus_ren_q   <= 1'b0;
      bus_wen_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_any) begin
            state_q     <= S_ACCESS;
            first_q     <= 1'b1;
            gnt_data_q  <= grant_data;
            last_data_q <= grant_data;
            if (grant_data) begin
              bus_addr_q  <= d_addr;
              bus_wdata_q <= d_wdata;
              bus_sel_q   <= d_sel;
              bus_wen_q   <= d_wen;
              bus_ren_q   <= ~d_wen;
            end else begin
              bus_addr_q  <= i_addr;
              bus_wdata_q <= '0;
              bus_sel_q   <= 4'hF;
              bus_wen_q   <= 1'b0;
              bus_ren_q   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          first_q <= 1'b0;
          if (finish_d || abort_d) begin
            state_q   <= S_DONE;
            bus_ren_q <= 1'b0;
            bus_wen_q <= 1'b0;
            if (gnt_data_q) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= cap_data_d;
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= cap_data_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;
  assign bus_ren   = bus_ren_q;
  assign bus_wen   = bus_wen_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory bus between instruction fetch (PC side) and data load/store.
- Sequences each access through a 3-state FSM and returns a one-cycle ready pulse.
- i_ready drives the PC advance (iready); d_ready releases load/store completion.
- Alternating priority on contention prevents starvation of either requester.

Parameters:
- TIMEOUT_CYCLES, 255: max bus_busy-high cycles in ACCESS before abort (used only with macro).
- ERR_DATA, 32'hBAD0_BAD0: read data returned on timeout abort.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction fetch request; held until i_ready.
- i_addr  in  32  fetch address (PC).
- i_rdata  out  32  fetched instruction, valid while i_ready=1.
- i_ready  out  1  one-cycle fetch-done pulse.
- d_ren  in  1  data read request; held until d_ready.
- d_wen  in  1  data write request; held until d_ready.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_sel  in  4  byte enables.
- d_rdata  out  32  load data, valid while d_ready=1.
- d_ready  out  1  one-cycle data-done pulse.
- bus_addr  out  32  registered bus address.
- bus_wdata  out  32  registered bus write data.
- bus_sel  out  4  registered byte enables (4'hF for fetch).
- bus_ren  out  1  bus read strobe.
- bus_wen  out  1  bus write strobe.
- bus_rdata  in  32  bus read data.
- bus_busy  in  1  memory busy; 0 = access complete.
- bus_err  out  1  timeout abort flag, pulses with ready.

Behaviour:
- Reset (async, RST=1): state=IDLE; all outputs 0; last_grant=DATA; wait counter=0; rdata registers=0.
- IDLE:
  - Data pending = d_ren|d_wen.
  - Only one requester pending: grant it.
  - Both pending: grant the one not equal to last_grant.
  - On grant: latch addr/wdata/sel, set last_grant, go ACCESS.
  - None pending: stay IDLE.
- ACCESS:
  - Strobes asserted from registered copies: fetch -> bus_ren=1, bus_sel=4'hF; data -> bus_wen=d_wen latched, bus_ren=~d_wen latched.
  - d_ren & d_wen both high is treated as a write.
  - bus_busy is ignored in the first ACCESS cycle.
  - From the 2nd cycle, bus_busy=0 -> capture bus_rdata into granted rdata register (writes capture 0), go DONE.
- DONE:
  - Strobes low; granted ready=1 for exactly this cycle; go IDLE.
  - Ungranted ready stays 0.
- Minimum latency: request sampled in IDLE at edge 0; ready high during cycle 3 (bus_busy=0 throughout).
- Back-to-back: a new grant is evaluated in the IDLE cycle after DONE, so throughput is 1 access per 4 cycles minimum.
- Request dropped mid-ACCESS: the transaction still completes and ready still pulses; the requester ignores it.
- Address/data changing mid-access: no effect; latched values are used.
- RST mid-ACCESS: immediate return to IDLE, strobes low; no ready pulse; in-flight access is lost.
- Wait counter: 8-bit minimum width; saturates and never wraps.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments each ACCESS cycle with bus_busy=1.
  - When the count reaches TIMEOUT_CYCLES: abort, load ERR_DATA into granted rdata, go DONE.
  - In DONE, bus_err=1 alongside ready.
  - Counter clears on entry to ACCESS.
- Undefined: no counter; ACCESS waits indefinitely; bus_err tied 0.

Test Plan:
- Reset: RST=1 mid-ACCESS -> all outputs 0 within the same cycle; after release, i_req=1 with bus_busy=0 -> i_ready pulse at cycle 3 with i_rdata=bus_rdata (e.g. 32'h00000013).
- Contention: i_req and d_ren both high from reset -> fetch granted first (last_grant=DATA); data served next; then with both still pending, fetch again (strict alternation).
- Store: d_wen=1, d_addr=32'h100, d_wdata=32'hCAFEF00D, d_sel=4'h3 -> bus_wen=1 with those values for the ACCESS duration, bus_ren=0, d_ready one cycle, d_rdata=0.
- Wait states: bus_busy high for 5 cycles after issue -> ready at cycle 8; addr stable throughout; exactly one ready pulse.
- Dropped request: d_ren deasserted during ACCESS -> access completes, d_ready still pulses once, then IDLE with no re-grant.
- Timeout (macro on, TIMEOUT_CYCLES=4): bus_busy stuck 1 -> after 4 busy cycles, i_ready=1, bus_err=1, i_rdata=32'hBAD0_BAD0; macro off -> no ready, bus_err stays 0.
